// File: rtl/stream_mux_rr_pkg.sv
// Shared helpers for the round-robin stream mux.
// Holds no types so channel width and pointer width stay local to each instance.
package stream_mux_rr_pkg;

  // Encodes a one-hot vector (up to 16 bits) into its bit index; zero input yields 0.
  function automatic logic [3:0] onehot_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// The priority pointer moves only when advance is asserted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W-1:0] win_idx;
  logic             found;

  always_comb begin
    int idx;
    grant   = '0;
    found   = 1'b0;
    win_idx = last_q;
    idx     = 0;
    // Scan from last_q+1 upward, wrapping through N-1 back to 0.
    for (int k = 0; k < N; k++) begin
      idx = (int'(last_q) + 1 + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && found) last_d = win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= PTR_W'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration
// and a single registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic [N_IN-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N_IN)-1:0] out_sel,
  input  logic                    out_ready
);

  localparam int SEL_W = $clog2(N_IN);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic              load;
  logic              xfer;
  logic [N_IN-1:0]   grant;
  logic [SEL_W-1:0]  gnt_idx;

  assign load = (state_q == EMPTY) || out_ready;
  // Reset blocks any transfer so nothing is accepted or replayed across it.
  assign xfer = load && (|in_valid) && !rst;

  rr_arbiter #(.N(N_IN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (xfer),
    .grant   (grant)
  );

  assign gnt_idx  = SEL_W'(onehot_idx(16'(grant)));
  assign in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      sel_d   = gnt_idx;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_IN=4, WIDTH=8): vector table plus
// hand-written stall and bounded-wait sequences.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.N_IN(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] din;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
    logic        chk_pay;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] D_SEQ = 32'h13121110;

  initial begin
    // {rst, in_valid, in_data, out_ready, exp in_ready, exp out_valid, exp data, exp sel, check payload}
    vecs[0]  = '{1'b1, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'b1111, D_SEQ,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 4'b0001, 32'h77665EA5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 4'b1111, D_SEQ,        1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 4'b1111, D_SEQ,        1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1};
    vecs[12] = '{1'b0, 4'b0101, D_SEQ,        1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    vecs[13] = '{1'b0, 4'b0101, D_SEQ,        1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 4'b0000, D_SEQ,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[15] = '{1'b0, 4'b0000, D_SEQ,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    // Idle cycles must not have moved priority: last winner was 2, so 3 wins.
    vecs[16] = '{1'b0, 4'b1111, D_SEQ,        1'b0, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1};
    vecs[17] = '{1'b1, 4'b1111, D_SEQ,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[18] = '{1'b0, 4'b1111, D_SEQ,        1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};

    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      rst       = vecs[v].rst;
      in_valid  = vecs[v].iv;
      in_data   = vecs[v].din;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      if (vecs[v].chk_pay) begin
        chk($sformatf("v%0d out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
        chk($sformatf("v%0d out_sel", v), 32'(out_sel), 32'(vecs[v].exp_sel));
      end
    end

    // Drain, then load a lone channel-2 word with out_ready low; bounded wait.
    in_valid  = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);
    in_valid  = 4'b0100;
    in_data   = 32'h005A0000;
    out_ready = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("lone load timeout", 32'(out_valid), 32'd1);
      chk("lone load latency", 32'(waited), 32'd1);
    end
    chk("lone load data", 32'(out_data), 32'h5A);
    chk("lone load sel", 32'(out_sel), 32'd2);

    // Stall with all channels requesting and their data churning.
    in_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      in_data = 32'hC3C3C3C3 ^ 32'(c * 32'h01010101);
      #1;
      chk($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d data", c), 32'(out_data), 32'h5A);
      chk($sformatf("stall%0d sel", c), 32'(out_sel), 32'd2);
      chk($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
    end
    // Release: next grant goes to channel 3 after the channel-2 word.
    in_data   = D_SEQ;
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk("release data", 32'(out_data), 32'h13);
    chk("release sel", 32'(out_sel), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
